// File: rtl/instruction_encoder_pkg.sv
// Shared definitions for the instruction encoder.
// Contents: opcode constants, bit positions of each encoded field, FIFO depth,
// maximum loop nesting depth, the input field bundle type and the word encoder.
package instruction_encoder_pkg;

    localparam int INSTR_W        = 18;
    localparam int OPCODE_W       = 5;
    localparam int FIFO_DEPTH     = 4;
    localparam int MAX_LOOP_DEPTH = 4;
    localparam int DEPTH_W        = 3;

    localparam logic [OPCODE_W-1:0] OP_MUL            = 5'd4;
    localparam logic [OPCODE_W-1:0] OP_MAX            = 5'd7;
    localparam logic [OPCODE_W-1:0] OP_SUM            = 5'd8;
    localparam logic [OPCODE_W-1:0] OP_COPY           = 5'd13;
    localparam logic [OPCODE_W-1:0] OP_ZERO           = 5'd14;
    localparam logic [OPCODE_W-1:0] OP_LOAD           = 5'd15;
    localparam logic [OPCODE_W-1:0] OP_STORE          = 5'd16;
    localparam logic [OPCODE_W-1:0] OP_START_IND_LOOP = 5'd17;
    localparam logic [OPCODE_W-1:0] OP_START_LOOP     = 5'd18;
    localparam logic [OPCODE_W-1:0] OP_JUMP_END_LOOP  = 5'd19;
    localparam logic [OPCODE_W-1:0] OP_FIRST_ILLEGAL  = 5'd20;

    // Bit positions (LSB of each field) inside the encoded word
    localparam int OPCODE_LSB = 13;
    localparam int FLAG_BIT   = 12;
    localparam int CP_SRC_LSB = 11;
    localparam int CP_DST_LSB = 9;
    localparam int APU_LSB    = 9;
    localparam int LS_REG_LSB = 7;
    localparam int HEIGHT_LSB = 5;
    localparam int WIDTH_LSB  = 3;
    localparam int ZERO_BIT   = 2;
    localparam int SKIP_BIT   = 1;
    localparam int LOOP_LSB   = 10;

    typedef struct packed {
        logic       flag;
        logic [3:0] apu;
        logic [1:0] reg_a;
        logic [1:0] reg_b;
        logic [1:0] height;
        logic [1:0] width;
        logic       zero_flag;
        logic       skip_flag;
        logic [2:0] loop_count;
    } fields_t;

    // Packs only the fields that belong to the opcode; every other bit is 0.
    function automatic logic [INSTR_W-1:0] encode_word(input logic [OPCODE_W-1:0] op,
                                                       input fields_t f);
        logic [INSTR_W-1:0] w;
        w = '0;
        w[OPCODE_LSB +: OPCODE_W] = op;
        case (op)
            OP_MUL, OP_MAX, OP_SUM: w[FLAG_BIT] = f.flag;
            OP_COPY: begin
                w[CP_SRC_LSB +: 2] = f.reg_a;
                w[CP_DST_LSB +: 2] = f.reg_b;
            end
            OP_ZERO: w[CP_SRC_LSB +: 2] = f.reg_a;
            OP_LOAD, OP_STORE: begin
                w[APU_LSB +: 4]    = f.apu;
                w[LS_REG_LSB +: 2] = f.reg_a;
                w[HEIGHT_LSB +: 2] = f.height;
                w[WIDTH_LSB +: 2]  = f.width;
                if (op == OP_LOAD) begin
                    w[ZERO_BIT] = f.zero_flag;
                    w[SKIP_BIT] = f.skip_flag;
                end
            end
            OP_START_IND_LOOP, OP_START_LOOP, OP_JUMP_END_LOOP:
                w[LOOP_LSB +: 3] = f.loop_count;
            default: ;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/instruction_encoder_if.sv
// Bus bundle of the instruction encoder.
// Upstream: in_valid/in_ready handshake plus instruction fields.
// Downstream: out_valid/out_ready handshake plus 18-bit out_raw word.
// Status: sticky err_illegal/err_loop, err_clear request, loop_depth.
// slave = encoder side, master = producer/consumer side.
interface instruction_encoder_if;
    import instruction_encoder_pkg::*;

    logic                in_valid;
    logic                in_ready;
    logic [OPCODE_W-1:0] opcode;
    logic                flag;
    logic [3:0]          apu;
    logic [1:0]          reg_a;
    logic [1:0]          reg_b;
    logic [1:0]          height;
    logic [1:0]          width;
    logic                zero_flag;
    logic                skip_flag;
    logic [2:0]          loop_count;
    logic                out_valid;
    logic                out_ready;
    logic [INSTR_W-1:0]  out_raw;
    logic                err_illegal;
    logic                err_loop;
    logic                err_clear;
    logic [DEPTH_W-1:0]  loop_depth;

    modport slave (
        input  in_valid, opcode, flag, apu, reg_a, reg_b, height, width,
               zero_flag, skip_flag, loop_count, out_ready, err_clear,
        output in_ready, out_valid, out_raw, err_illegal, err_loop, loop_depth
    );

    modport master (
        output in_valid, opcode, flag, apu, reg_a, reg_b, height, width,
               zero_flag, skip_flag, loop_count, out_ready, err_clear,
        input  in_ready, out_valid, out_raw, err_illegal, err_loop, loop_depth
    );

endinterface

// File: rtl/instr_fifo.sv
// Small synchronous FIFO holding encoded instruction words.
// Ports: clk, rst_n (async active-low), push/wdata (write), pop (read),
// rvalid/rdata (head word, rdata is 0 when empty), count (occupancy).
module instr_fifo #(
    parameter  int WIDTH = 18,
    parameter  int DEPTH = 4,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic             rvalid,
    output logic [WIDTH-1:0] rdata,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok, pop_ok;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        push_ok  = push && (count_q != CNT_W'(DEPTH));
        pop_ok   = pop && (count_q != '0);
        wr_ptr_d = push_ok ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop_ok ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: an empty count masks whatever it holds.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata;
    end

    assign rvalid = (count_q != '0);
    assign rdata  = rvalid ? mem_q[rd_ptr_q] : '0;
    assign count  = count_q;

endmodule

// File: rtl/instruction_encoder.sv
// Instruction encoder: accepts instruction field sets, packs them into 18-bit
// words and queues them in a 4-entry FIFO; tracks loop nesting and flags
// illegal opcodes and loop over/underflow.
// Ports: clk, reset (async active-low), bus (instruction_encoder_if.slave).
module instruction_encoder
    import instruction_encoder_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    instruction_encoder_if.slave  bus
);

    logic [DEPTH_W-1:0] loop_depth_q, loop_depth_d;
    logic               err_illegal_q, err_illegal_d;
    logic               err_loop_q, err_loop_d;
    logic               rdy_en_q, rdy_en_d;
    fields_t            fields;
    logic [INSTR_W-1:0] word;
    logic [2:0]         fifo_count;
    logic               accept, illegal, is_open, is_close, loop_err, push, pop;

    always_comb begin
        fields = '{flag: bus.flag, apu: bus.apu, reg_a: bus.reg_a, reg_b: bus.reg_b,
                   height: bus.height, width: bus.width, zero_flag: bus.zero_flag,
                   skip_flag: bus.skip_flag, loop_count: bus.loop_count};
        word     = encode_word(bus.opcode, fields);
        accept   = bus.in_valid && bus.in_ready;
        illegal  = (bus.opcode >= OP_FIRST_ILLEGAL);
        is_open  = (bus.opcode == OP_START_IND_LOOP) || (bus.opcode == OP_START_LOOP);
        is_close = (bus.opcode == OP_JUMP_END_LOOP);
        loop_err = (is_close && (loop_depth_q == '0)) ||
                   (is_open && (loop_depth_q == DEPTH_W'(MAX_LOOP_DEPTH)));
        // Illegal and loop-faulting instructions are still consumed, just dropped.
        push     = accept && !illegal && !loop_err;
        pop      = bus.out_valid && bus.out_ready;

        loop_depth_d = loop_depth_q;
        if (push && is_open)  loop_depth_d = loop_depth_q + 3'd1;
        if (push && is_close) loop_depth_d = loop_depth_q - 3'd1;

        // A fresh error outranks a same-cycle clear.
        err_illegal_d = (accept && illegal) || (err_illegal_q && !bus.err_clear);
        err_loop_d    = (accept && !illegal && loop_err) || (err_loop_q && !bus.err_clear);
        rdy_en_d      = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            loop_depth_q  <= '0;
            err_illegal_q <= 1'b0;
            err_loop_q    <= 1'b0;
            rdy_en_q      <= 1'b0;
        end else begin
            loop_depth_q  <= loop_depth_d;
            err_illegal_q <= err_illegal_d;
            err_loop_q    <= err_loop_d;
            rdy_en_q      <= rdy_en_d;
        end
    end

    instr_fifo #(
        .WIDTH (INSTR_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (reset),
        .push   (push),
        .wdata  (word),
        .pop    (pop),
        .rvalid (bus.out_valid),
        .rdata  (bus.out_raw),
        .count  (fifo_count)
    );

    // rdy_en_q holds in_ready low through reset and releases it one edge later;
    // a pop in the same cycle does not make room for a push.
    assign bus.in_ready    = rdy_en_q && (fifo_count != 3'(FIFO_DEPTH));
    assign bus.err_illegal = err_illegal_q;
    assign bus.err_loop    = err_loop_q;
    assign bus.loop_depth  = loop_depth_q;

endmodule

// File: tb/tb_instruction_encoder.sv
// Directed self-checking bench for instruction_encoder.
module tb_instruction_encoder;
    import instruction_encoder_pkg::*;

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    instruction_encoder_if bus ();

    instruction_encoder dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic set_fields(input logic [4:0] op, input fields_t f);
        bus.opcode     = op;
        bus.flag       = f.flag;
        bus.apu        = f.apu;
        bus.reg_a      = f.reg_a;
        bus.reg_b      = f.reg_b;
        bus.height     = f.height;
        bus.width      = f.width;
        bus.zero_flag  = f.zero_flag;
        bus.skip_flag  = f.skip_flag;
        bus.loop_count = f.loop_count;
    endtask

    // Called at a negedge; returns at the negedge right after acceptance.
    task automatic send(input logic [4:0] op, input fields_t f);
        int t;
        t = 0;
        set_fields(op, f);
        bus.in_valid = 1'b1;
        while (!bus.in_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!bus.in_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL send_timeout: in_ready stayed 0 for opcode %0d", op);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic clear_pulse();
        bus.err_clear = 1'b1;
        @(negedge clk);
        bus.err_clear = 1'b0;
    endtask

    function automatic fields_t lc(input logic [2:0] n);
        fields_t f;
        f = '0;
        f.loop_count = n;
        return f;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        #2 reset = 1'b0;
        @(negedge clk);
        chk("reset_in_ready", {31'd0, bus.in_ready}, 0);
        chk("reset_out_valid", {31'd0, bus.out_valid}, 0);
        chk("reset_out_raw", {14'd0, bus.out_raw}, 0);
        chk("reset_loop_depth", {29'd0, bus.loop_depth}, 0);
        chk("reset_err_illegal", {31'd0, bus.err_illegal}, 0);
        chk("reset_err_loop", {31'd0, bus.err_loop}, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("in_ready_after_release", {31'd0, bus.in_ready}, 1);
    endtask

    task automatic test_encode();
        logic [4:0]  ops [6];
        fields_t     fs  [6];
        logic [17:0] exp [6];
        ops[0] = OP_LOAD;  exp[0] = 18'h1EB3C;
        fs[0]  = '{flag:1'b0, apu:4'd5, reg_a:2'd2, reg_b:2'd0, height:2'd1, width:2'd3,
                   zero_flag:1'b1, skip_flag:1'b0, loop_count:3'd0};
        ops[1] = OP_STORE; exp[1] = 18'h214C8;
        fs[1]  = '{flag:1'b1, apu:4'hA, reg_a:2'd1, reg_b:2'd3, height:2'd2, width:2'd1,
                   zero_flag:1'b1, skip_flag:1'b1, loop_count:3'd7};
        ops[2] = OP_MUL;   exp[2] = 18'h09000;
        fs[2]  = '{flag:1'b1, apu:4'hF, reg_a:2'd3, reg_b:2'd3, height:2'd3, width:2'd3,
                   zero_flag:1'b1, skip_flag:1'b1, loop_count:3'd7};
        ops[3] = OP_ZERO;  exp[3] = 18'h1D800;
        fs[3]  = '{flag:1'b1, apu:4'h0, reg_a:2'd3, reg_b:2'd2, height:2'd0, width:2'd0,
                   zero_flag:1'b0, skip_flag:1'b0, loop_count:3'd0};
        ops[4] = 5'd2;     exp[4] = 18'h04000;
        fs[4]  = '1;
        ops[5] = OP_MAX;   exp[5] = 18'h0F000;
        fs[5]  = '0;
        fs[5].flag = 1'b1;
        for (int i = 0; i < 6; i++) begin
            send(ops[i], fs[i]);
            chk($sformatf("encode%0d_valid", i), {31'd0, bus.out_valid}, 1);
            chk($sformatf("encode%0d_raw", i), {14'd0, bus.out_raw}, {14'd0, exp[i]});
        end
        @(negedge clk);
        chk("encode_drained", {31'd0, bus.out_valid}, 0);
    endtask

    task automatic test_copy_loop();
        fields_t f;
        f = '0;
        f.reg_a = 2'd1;
        f.reg_b = 2'd3;
        send(OP_COPY, f);
        chk("copy_raw", {14'd0, bus.out_raw}, 32'h1AE00);
        send(OP_START_LOOP, lc(3'd5));
        chk("start_loop_raw", {14'd0, bus.out_raw}, 32'h25400);
        chk("start_loop_depth", {29'd0, bus.loop_depth}, 1);
        send(OP_JUMP_END_LOOP, lc(3'd2));
        chk("end_loop_raw", {14'd0, bus.out_raw}, 32'h26800);
        chk("end_loop_depth", {29'd0, bus.loop_depth}, 0);
        @(negedge clk);
    endtask

    task automatic test_illegal();
        send(5'd21, '0);
        chk("illegal_no_output", {31'd0, bus.out_valid}, 0);
        chk("illegal_err_set", {31'd0, bus.err_illegal}, 1);
        chk("illegal_no_loop_err", {31'd0, bus.err_loop}, 0);
        clear_pulse();
        chk("illegal_err_cleared", {31'd0, bus.err_illegal}, 0);
        send(5'd22, '0);
        bus.err_clear = 1'b1;
        send(5'd20, '0);
        bus.err_clear = 1'b0;
        chk("illegal_beats_clear", {31'd0, bus.err_illegal}, 1);
        clear_pulse();
        chk("illegal_err_cleared2", {31'd0, bus.err_illegal}, 0);
    endtask

    task automatic test_loop_err();
        send(OP_JUMP_END_LOOP, lc(3'd1));
        chk("underflow_err", {31'd0, bus.err_loop}, 1);
        chk("underflow_no_output", {31'd0, bus.out_valid}, 0);
        chk("underflow_depth", {29'd0, bus.loop_depth}, 0);
        clear_pulse();
        chk("loop_err_cleared", {31'd0, bus.err_loop}, 0);
        for (int i = 0; i < 5; i++) begin
            send(OP_START_LOOP, lc(3'(i)));
            if (i < 4) chk($sformatf("nest%0d_depth", i), {29'd0, bus.loop_depth}, i + 1);
        end
        chk("overflow_err", {31'd0, bus.err_loop}, 1);
        chk("overflow_depth", {29'd0, bus.loop_depth}, 4);
        chk("overflow_no_output", {31'd0, bus.out_valid}, 0);
        for (int i = 0; i < 4; i++) send(OP_JUMP_END_LOOP, lc(3'd0));
        chk("unnest_depth", {29'd0, bus.loop_depth}, 0);
        clear_pulse();
        chk("loop_err_cleared2", {31'd0, bus.err_loop}, 0);
    endtask

    task automatic test_back_to_back();
        logic [17:0] exp [5];
        logic        acc;
        exp[0] = 18'h00000; exp[1] = 18'h02000; exp[2] = 18'h04000;
        exp[3] = 18'h06000; exp[4] = 18'h09000;
        bus.out_ready = 1'b0;
        set_fields(5'd0, '0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("b2b_ready%0d", i), {31'd0, bus.in_ready}, 1);
            bus.opcode   = 5'(i);
            bus.in_valid = 1'b1;
            @(negedge clk);
        end
        bus.opcode = OP_MUL;
        bus.flag   = 1'b1;
        chk("b2b_full_not_ready", {31'd0, bus.in_ready}, 0);
        bus.out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("b2b_valid%0d", k), {31'd0, bus.out_valid}, 1);
            chk($sformatf("b2b_raw%0d", k), {14'd0, bus.out_raw}, {14'd0, exp[k]});
            acc = bus.in_valid && bus.in_ready;
            @(negedge clk);
            if (acc) bus.in_valid = 1'b0;
        end
        chk("b2b_fifth_accepted", {31'd0, bus.in_valid}, 0);
        chk("b2b_drained", {31'd0, bus.out_valid}, 0);
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 1'b0;
        send(5'd23, '0);
        send(OP_START_LOOP, lc(3'd1));
        send(5'd1, '0);
        send(5'd2, '0);
        chk("mid_pre_valid", {31'd0, bus.out_valid}, 1);
        chk("mid_pre_depth", {29'd0, bus.loop_depth}, 1);
        #2 reset = 1'b0;
        #1;
        chk("mid_out_valid", {31'd0, bus.out_valid}, 0);
        chk("mid_out_raw", {14'd0, bus.out_raw}, 0);
        chk("mid_depth", {29'd0, bus.loop_depth}, 0);
        chk("mid_in_ready", {31'd0, bus.in_ready}, 0);
        chk("mid_err_illegal", {31'd0, bus.err_illegal}, 0);
        @(negedge clk);
        reset = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("mid_no_stale%0d", i), {31'd0, bus.out_valid}, 0);
        end
        chk("mid_ready_back", {31'd0, bus.in_ready}, 1);
    endtask

    initial begin
        vectors       = 0;
        miscompares   = 0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.err_clear = 1'b0;
        set_fields(5'd0, '0);
        test_reset();
        test_encode();
        test_copy_loop();
        test_illegal();
        test_loop_err();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/instruction_encoder.md
INSTRUCTION_ENCODER -- requirements
Module: instruction_encoder

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-low reset.
REQ-003 in_valid / in_ready  input / output  1 / 1  upstream handshake; a field set is accepted when both are 1 on a clock edge.
REQ-004 opcode  input  5  instruction class: 0-14 processing, 15 LOAD, 16 STORE, 17 START_INDEPENDENT_LOOP, 18 START_LOOP, 19 JUMP_OR_END_LOOP.
REQ-005 flag  input  1  mode bit for MUL(4), MAX(7), SUM(8).
REQ-006 apu  input  4  target APU for LOAD/STORE.
REQ-007 reg_a / reg_b  input  2 / 2  register selects: COPY src/dst, ZERO reg, LOAD/STORE reg (reg_a only).
REQ-008 height / width  input  2 / 2  tile shape for LOAD/STORE.
REQ-009 zero_flag / skip_flag  input  1 / 1  LOAD-only modifiers.
REQ-010 loop_count  input  3  loop operand for opcodes 17-19.
REQ-011 out_valid / out_ready  output / input  1 / 1  downstream handshake; a word is consumed when both are 1 on a clock edge.
REQ-012 out_raw  output  18  encoded instruction word at FIFO head; 0 when out_valid=0.
REQ-013 err_illegal / err_loop  output  1 / 1  sticky error flags.
REQ-014 err_clear  input  1  synchronous clear of both error flags.
REQ-015 loop_depth  output  3  current open-loop nesting depth.

Function
REQ-016 out_raw[17:13] SHALL equal the accepted opcode; all bits not listed in REQ-017..REQ-021 SHALL be 0.
REQ-017 Opcodes 4, 7, 8: bit12 = flag; opcode 13: [12:11]=reg_a, [10:9]=reg_b; opcode 14: [12:11]=reg_a; all other processing opcodes: [12:0]=0.
REQ-018 LOAD: [12:9]=apu, [8:7]=reg_a, [6:5]=height, [4:3]=width, [2]=zero_flag, [1]=skip_flag, [0]=0.
REQ-019 STORE: [12:9]=apu, [8:7]=reg_a, [6:5]=height, [4:3]=width, [2:0]=0.
REQ-020 Opcodes 17-19: [12:10]=loop_count, [9:0]=0.
REQ-021 Opcode >=20 is illegal: it is consumed (in_ready handshake completes), not enqueued, and sets err_illegal on the next cycle.
REQ-022 The encoded word SHALL be written into a 4-entry FIFO; earliest out_valid is the cycle after acceptance (latency 1).
REQ-023 in_ready = FIFO count < 4, independent of same-cycle pop.
REQ-024 Simultaneous push and pop with count in 1..3 SHALL leave count unchanged and preserve order.
REQ-025 Opcodes 17/18 increment loop_depth; opcode 19 decrements it.
REQ-026 Opcode 19 at depth 0, or opcode 17/18 at depth 4, SHALL set err_loop, leave depth unchanged, and not enqueue the word.
REQ-027 Error flags stay set until err_clear=1 or reset; a new error on the same cycle as err_clear wins (flag stays 1).
REQ-028 out_raw and out_valid SHALL be driven from registers/FIFO storage only, never combinationally from the input fields.

Reset
REQ-029 On reset assertion: FIFO emptied, out_valid=0, out_raw=0, in_ready=0 while asserted, loop_depth=0, err_illegal=0, err_loop=0.
REQ-030 in_ready SHALL rise in the first cycle after reset deassertion.
REQ-031 Reset mid-operation SHALL discard all buffered words without emitting partial output.

Structure
REQ-032 A shared package SHALL hold the opcode constants, the bit positions of each field, FIFO depth (4), and maximum loop depth (4).
REQ-033 The FIFO SHALL be a separate sub-module, instr_fifo, parameterised by width and depth.

Verification
REQ-034 LOAD with apu=5, reg_a=2, height=1, width=3, zero_flag=1, skip_flag=0 -> out_raw=0x1EB3C one cycle later.
REQ-035 COPY with reg_a=1, reg_b=3 -> 0x1AE00; START_LOOP with loop_count=5 -> 0x25400, loop_depth=1.
REQ-036 opcode=21 -> handshake completes, out_valid stays 0, err_illegal=1; err_clear pulse -> err_illegal=0.
REQ-037 JUMP_OR_END_LOOP at depth 0 -> err_loop=1, nothing enqueued; five nested START_LOOPs -> fifth sets err_loop, depth=4.
REQ-038 out_ready=0 with 5 back-to-back pushes -> in_ready=0 after the 4th; release out_ready -> 4 words emitted in order, and the 5th is accepted once in_ready=1.
REQ-039 Reset asserted with 3 words buffered -> out_valid=0, loop_depth=0 immediately; no stale word after release.
